// File: rtl/shared_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : shared_reg_arbiter_if
//  Purpose  : Bundles the request/grant handshake and the shared-register
//             data paths of the two-requester round-robin arbiter.
//  Signals  : stall               - pipeline control, blocks new grants
//             req0/wr0/wdata0     - requester 0 request, write qualifier, data
//             req1/wr1/wdata1     - requester 1 request, write qualifier, data
//             gnt0/gnt1           - one-cycle grants (registered)
//             rdata               - shared register contents
//             busy                - high while a grant is active
//  Modports : slave  - the arbiter (consumes requests, drives grants/rdata)
//             master - the requester/control side
//  Revision : 1.0 - initial release
// ============================================================================
interface shared_reg_arbiter_if;

   logic        stall;
   logic        req0;
   logic        wr0;
   logic [63:0] wdata0;
   logic        req1;
   logic        wr1;
   logic [63:0] wdata1;
   logic        gnt0;
   logic        gnt1;
   logic [63:0] rdata;
   logic        busy;

   modport slave (
      input  stall,
      input  req0,
      input  wr0,
      input  wdata0,
      input  req1,
      input  wr1,
      input  wdata1,
      output gnt0,
      output gnt1,
      output rdata,
      output busy
   );

   modport master (
      output stall,
      output req0,
      output wr0,
      output wdata0,
      output req1,
      output wr1,
      output wdata1,
      input  gnt0,
      input  gnt1,
      input  rdata,
      input  busy
   );

endinterface : shared_reg_arbiter_if
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_reg_arbiter
//  Purpose  : Two-requester round-robin arbiter owning one shared 64-bit
//             register. One requester is granted per cycle; its write data is
//             committed on the edge that ends its grant cycle.
//  Ports    : clk    - system clock, rising edge
//             reset  - asynchronous, active-high, clears all state
//             bus    - shared_reg_arbiter_if.slave (stall, req/wr/wdata x2,
//                      gnt0/gnt1, rdata, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter (
   input  wire                    clk,
   input  wire                    reset,
   shared_reg_arbiter_if.slave    bus
);

   // One-hot-style encoding: each grant is a state bit, so the grant outputs
   // are taken straight from flip-flops with no decode glitches.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_G0   = 2'b01;
   localparam logic [1:0] ST_G1   = 2'b10;

   logic [1:0]  state_q;
   logic [1:0]  state_d;
   logic        pri_q;      // 0: requester 0 wins a tie, 1: requester 1
   logic        pri_d;
   logic [63:0] data_q;     // the shared register
   logic [63:0] data_d;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // The current requester still holds its request during its own grant
   // cycle, so only the other requester's request is considered when leaving
   // a grant state; otherwise the same requester would be re-granted.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (bus.stall) begin
               state_d = ST_IDLE;
            end else if (bus.req0 && bus.req1) begin
               state_d = pri_q ? ST_G1 : ST_G0;
            end else if (bus.req0) begin
               state_d = ST_G0;
            end else if (bus.req1) begin
               state_d = ST_G1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_G0: begin
            state_d = (bus.req1 && !bus.stall) ? ST_G1 : ST_IDLE;
         end
         ST_G1: begin
            state_d = (bus.req0 && !bus.stall) ? ST_G0 : ST_IDLE;
         end
         default: begin
            // Unreachable encoding: recover to IDLE.
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic (Moore: depends on the state register only)
   // -------------------------------------------------------------------------
   always_comb begin
      bus.gnt0  = (state_q == ST_G0);
      bus.gnt1  = (state_q == ST_G1);
      bus.busy  = (state_q == ST_G0) || (state_q == ST_G1);
      bus.rdata = data_q;
   end

   // -------------------------------------------------------------------------
   // Commit and priority update for the grant being completed this cycle.
   // A grant without the write qualifier (or with the request withdrawn)
   // leaves the register untouched; the pointer still rotates so the other
   // requester wins the next tie.
   // -------------------------------------------------------------------------
   always_comb begin
      data_d = data_q;
      pri_d  = pri_q;
      case (state_q)
         ST_G0: begin
            pri_d = 1'b1;
            if (bus.req0 && bus.wr0) begin
               data_d = bus.wdata0;
            end
         end
         ST_G1: begin
            pri_d = 1'b0;
            if (bus.req1 && bus.wr1) begin
               data_d = bus.wdata1;
            end
         end
         default: begin
            data_d = data_q;
            pri_d  = pri_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pri_q  <= 1'b0;
         data_q <= 64'd0;
      end else begin
         pri_q  <= pri_d;
         data_q <= data_d;
      end
   end

endmodule : shared_reg_arbiter
`default_nettype wire
